// File: rtl/x31_in_driver.sv
// Side-band writer for x31: debounced trigger flag, 1-second tick flag and seconds count,
// merged read-modify-write into the register file with retry on CPU write collisions.
module x31_in_driver #(
  parameter int DATA_WIDTH      = 32,
  parameter int TICK_DIV        = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trigger_raw,
  input  logic                  cpu_we,
  input  logic [4:0]            cpu_ad,
  input  logic [DATA_WIDTH-1:0] x31_out,
  output logic [DATA_WIDTH-1:0] x31_in,
  output logic                  in_EN,
  output logic [15:0]           seconds
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    PRESSED,
    REL
  } db_state_t;

  db_state_t        state;
  db_state_t        state_next;
  logic [DB_W-1:0]  db_cnt;
  logic [DB_W-1:0]  db_cnt_next;
  logic             sync_q;
  logic             trig_s;
  logic             trig_evt;
  logic [PRE_W-1:0] pre_cnt;
  logic             tick_evt;
  logic             trig_pend;
  logic             tick_pend;
  logic             collision;
  logic             clear_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      trig_s <= 1'b0;
    end else begin
      sync_q <= trigger_raw;
      trig_s <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // The counter restarts at 1 on each level change so the first stable sample already counts.
  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    case (state)
      IDLE: begin
        if (trig_s) begin
          state_next  = ARM;
          db_cnt_next = DB_W'(1);
        end
      end
      ARM: begin
        if (!trig_s) begin
          state_next = IDLE;
        end else if (db_cnt == DB_MAX) begin
          state_next = PRESSED;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!trig_s) begin
          state_next  = REL;
          db_cnt_next = DB_W'(1);
        end
      end
      REL: begin
        if (trig_s) begin
          state_next = PRESSED;
        end else if (db_cnt == DB_MAX) begin
          state_next = IDLE;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    trig_evt = 1'b0;
    if (state == ARM && trig_s && db_cnt == DB_MAX) begin
      trig_evt = 1'b1;
    end
  end

  assign tick_evt = (pre_cnt == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      seconds <= 16'd0;
    end else if (tick_evt) begin
      pre_cnt <= '0;
      seconds <= seconds + 16'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // A CPU write to x31 overrides our side-band write, so the flags must survive it and retry.
  assign collision = cpu_we && (cpu_ad == 5'd31);
  assign clear_ok  = in_EN && !collision;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_pend <= 1'b0;
      tick_pend <= 1'b0;
    end else begin
      trig_pend <= trig_evt || (trig_pend && !clear_ok);
      tick_pend <= tick_evt || (tick_pend && !clear_ok);
    end
  end

  assign in_EN  = trig_pend || tick_pend;
  assign x31_in = {seconds, x31_out[15:2], x31_out[1] | tick_pend, x31_out[0] | trig_pend};

endmodule

// File: tb/tb_x31_in_driver.sv
// Directed bench for x31_in_driver with TICK_DIV=10 and DEBOUNCE_CYCLES=4; cyc counts
// rising edges since the last reset release and all sampling happens on falling edges.
module tb_x31_in_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_raw;
  logic        cpu_we;
  logic [4:0]  cpu_ad;
  logic [31:0] x31_out;
  logic [31:0] x31_in;
  logic        in_EN;
  logic [15:0] seconds;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  x31_in_driver #(
    .DATA_WIDTH(32),
    .TICK_DIV(10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .trigger_raw(trigger_raw),
    .cpu_we(cpu_we),
    .cpu_ad(cpu_ad),
    .x31_out(x31_out),
    .x31_in(x31_in),
    .in_EN(in_EN),
    .seconds(seconds)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic raw, input logic we, input logic [4:0] ad,
                               input logic [31:0] xo);
    trigger_raw = raw;
    cpu_we      = we;
    cpu_ad      = ad;
    x31_out     = xo;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic runTo(input int n);
    while (cyc < n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_in_en", 32'(in_EN), 32'd0);
    checkOutput("rst_seconds", 32'(seconds), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'hFFFF_ABCD);
    #1;
    checkOutput("rst_x31_in", x31_in, 32'h0000_ABCD);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    cyc   = 0;

    // First tick lands on the 10th edge after reset release
    runTo(9);
    checkOutput("pre_tick_idle", 32'(in_EN), 32'd0);
    runTo(10);
    checkOutput("tick1_en", 32'(in_EN), 32'd1);
    checkOutput("tick1_data", x31_in, 32'h0001_0002);
    checkOutput("tick1_seconds", 32'(seconds), 32'd1);
    runTo(11);
    checkOutput("tick1_clear", 32'(in_EN), 32'd0);

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    runTo(17);
    checkOutput("press_wait", 32'(in_EN), 32'd0);
    runTo(18);
    checkOutput("press_en", 32'(in_EN), 32'd1);
    checkOutput("press_data", x31_in, 32'h0001_0001);
    runTo(19);
    checkOutput("press_once", 32'(in_EN), 32'd0);
    runTo(20);
    checkOutput("tick2_data", x31_in, 32'h0002_0002);
    runTo(21);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    for (int e = 22; e <= 29; e++) begin
      runTo(e);
      checkOutput("release_quiet", 32'(in_EN), 32'd0);
    end
    runTo(30);
    checkOutput("tick3_data", x31_in, 32'h0003_0002);

    // Press bounces 1,1,0,0 x3 then holds; accepted only after 4 stable samples
    for (int i = 0; i < 12; i++) begin
      applyStimulus(((i / 2) % 2) == 0, 1'b0, 5'd0, 32'h0);
      runTo(31 + i);
      checkOutput("bounce_quiet", 32'(x31_in[0]), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    for (int e = 43; e <= 48; e++) begin
      runTo(e);
      checkOutput("bounce_settle", 32'(x31_in[0]), 32'd0);
    end
    runTo(49);
    checkOutput("bounce_en", 32'(in_EN), 32'd1);
    checkOutput("bounce_data", x31_in, 32'h0004_0001);
    runTo(50);
    checkOutput("tick5_data", x31_in, 32'h0005_0002);
    runTo(51);
    checkOutput("tick5_clear", 32'(in_EN), 32'd0);

    for (int j = 0; j < 8; j++) begin
      applyStimulus(((j / 2) % 2) == 1, 1'b0, 5'd0, 32'h0);
      runTo(52 + j);
      checkOutput("rel_bounce_quiet", 32'(x31_in[0]), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    for (int e = 60; e <= 69; e++) begin
      runTo(e);
      checkOutput("rel_settle_quiet", 32'(x31_in[0]), 32'd0);
    end
    runTo(70);
    checkOutput("tick7_data", x31_in, 32'h0007_0002);
    checkOutput("tick7_seconds", 32'(seconds), 32'd7);

    // CPU writes x31 on edges 78..80 while the trigger is pending; tick at 80 joins it
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    runTo(76);
    checkOutput("coll_pre", 32'(in_EN), 32'd0);
    runTo(77);
    checkOutput("coll_en0", 32'(in_EN), 32'd1);
    checkOutput("coll_data0", x31_in, 32'h0007_0001);
    applyStimulus(1'b1, 1'b1, 5'd31, 32'h0);
    runTo(78);
    checkOutput("coll_en1", 32'(in_EN), 32'd1);
    runTo(79);
    checkOutput("coll_en2", 32'(in_EN), 32'd1);
    checkOutput("coll_data2", x31_in, 32'h0007_0001);
    runTo(80);
    checkOutput("coll_en3", 32'(in_EN), 32'd1);
    checkOutput("coll_merge", x31_in, 32'h0008_0003);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    runTo(81);
    checkOutput("coll_done", 32'(in_EN), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);

    runTo(89);
    applyStimulus(1'b0, 1'b1, 5'd30, 32'h0);
    runTo(90);
    checkOutput("ad30_en", 32'(in_EN), 32'd1);
    checkOutput("ad30_data", x31_in, 32'h0009_0002);
    runTo(91);
    checkOutput("ad30_no_stall", 32'(in_EN), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd31, 32'h0);
    runTo(100);
    checkOutput("we0_en", 32'(in_EN), 32'd1);
    runTo(101);
    checkOutput("we0_no_stall", 32'(in_EN), 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);

    // Software bits 0x1234 in [15:2] pass through; x31_out[31:16] is ignored
    runTo(108);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0000_48D3);
    runTo(109);
    checkOutput("sw_idle_en", 32'(in_EN), 32'd0);
    checkOutput("sw_idle_data", x31_in, 32'h000A_48D3);
    runTo(110);
    checkOutput("sw_tick_en", 32'(in_EN), 32'd1);
    checkOutput("sw_tick_data", x31_in, 32'h000B_48D3);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'hFFFF_48D0);
    #1;
    checkOutput("sw_fresh_merge", x31_in, 32'h000B_48D2);
    runTo(111);
    checkOutput("sw_after", x31_in, 32'h000B_48D0);

    // Reset while the debouncer is in ARM (edge 115, db_cnt=2)
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    runTo(115);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("arm_rst_en", 32'(in_EN), 32'd0);
    checkOutput("arm_rst_seconds", 32'(seconds), 32'd0);
    checkOutput("arm_rst_data", x31_in, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int e = 1; e <= 9; e++) begin
      runTo(e);
      checkOutput("arm_rst_quiet", 32'(in_EN), 32'd0);
    end
    runTo(10);
    checkOutput("rst2_tick_data", x31_in, 32'h0001_0002);
    checkOutput("rst2_seconds", 32'(seconds), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
